// File: rtl/input_cond.sv
// input_cond
//
// Conditions the raw front-panel controls of the clock: three slide switches
// and one start/stop pushbutton. Every input is brought into the clk domain by
// a two-flop synchronizer and then filtered by its own debouncer. Each
// qualified activation is turned into a registered one-cycle pulse.
//
// Build option:
//   DEBOUNCE_EN - when defined, each input needs DB_CYCLES consecutive
//                 synchronized samples that differ from the current stable
//                 level before that level is accepted. When undefined, there
//                 are no counters and the stable level follows the
//                 synchronizer output every edge (DB_CYCLES is then ignored).
//
// Parameters:
//   DB_CYCLES   debounce qualification time in clk cycles (legal 2..2^20-1)
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   SW[2:0]     raw slide switches: [0] set time, [1] stop watch, [2] set alarm
//   KEY         raw start/stop pushbutton, active-low
//   set_time    one-cycle pulse on a qualified rise of SW[0]
//   stop_watch  one-cycle pulse on a qualified rise of SW[1]
//   set_alarm   one-cycle pulse on a qualified rise of SW[2]
//   strtStp     one-cycle pulse on a qualified press (1->0) of KEY
//   sw_lvl      debounced stable level of SW
module input_cond #(
    parameter int DB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] SW,
    input  logic       KEY,
    output logic       set_time,
    output logic       stop_watch,
    output logic       set_alarm,
    output logic       strtStp,
    output logic [2:0] sw_lvl
);

    // Channel 3 is the active-low pushbutton, so its idle level is 1; the
    // switches idle at 0. Each channel pulses when it settles at the opposite
    // of its idle level.
    localparam logic [3:0] IDLE_VAL   = 4'b1000;
    localparam logic [3:0] ACTIVE_VAL = ~IDLE_VAL;

    if (DB_CYCLES < 2 || DB_CYCLES > 1048575) begin : g_bad_db_cycles
        $error("input_cond: DB_CYCLES out of range 2..2^20-1");
    end

    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] stable;
    logic [3:0] update;
    logic [3:0] pulse_q;

    assign raw = {KEY, SW};

    // Two-flop synchronizers, reset to each channel's idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE_VAL;
            sync2 <= IDLE_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES);

    logic [CW-1:0] count [4];

    // A channel updates on the edge where it has already disagreed with
    // stable for DB_CYCLES-1 counted edges and still disagrees.
    always_comb begin
        update = '0;
        for (int i = 0; i < 4; i++) begin
            update[i] = (sync2[i] != stable[i]) && (count[i] == CW'(DB_CYCLES - 1));
        end
    end

    // Per-channel debounce counter: any agreement with stable restarts the
    // qualification window, so short excursions never reach the update edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= IDLE_VAL;
            for (int i = 0; i < 4; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    count[i] <= '0;
                end else if (update[i]) begin
                    stable[i] <= sync2[i];
                    count[i]  <= '0;
                end else begin
                    count[i] <= count[i] + CW'(1);
                end
            end
        end
    end
`else
    // Without debouncing every difference is accepted on the next edge.
    always_comb begin
        update = sync2 ^ stable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= IDLE_VAL;
        end else begin
            stable <= sync2;
        end
    end
`endif

    // Registered pulses: set on the update edge when the new level is the
    // channel's active level, so each held activation yields exactly one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= update & ~(sync2 ^ ACTIVE_VAL);
        end
    end

    assign set_time   = pulse_q[0];
    assign stop_watch = pulse_q[1];
    assign set_alarm  = pulse_q[2];
    assign strtStp    = pulse_q[3];
    assign sw_lvl     = stable[2:0];

endmodule

// File: tb/tb_input_cond.sv
// tb_input_cond
//
// Directed bench for input_cond with DB_CYCLES = 8. The same scenarios run in
// both builds; the expected pulse timing and excursion behaviour are derived
// from whether DEBOUNCE_EN is defined.
//
// Inputs are always changed 1 time unit after a rising edge, so the next edge
// is the sampling edge N. Outputs are observed 1 time unit after each edge.
// Edge index 1 is edge N, so a pulse that is high for the cycle following
// edge N+LAT is seen at index LAT+1.
module tb_input_cond;

    localparam int DB = 8;
`ifdef DEBOUNCE_EN
    localparam int LAT      = DB + 1;
    localparam bit DEBOUNCE = 1'b1;
`else
    localparam int LAT      = 2;
    localparam bit DEBOUNCE = 1'b0;
`endif
    localparam int FIRST = LAT + 1;

    logic       clk;
    logic       rst_n;
    logic [2:0] SW;
    logic       KEY;
    logic       set_time;
    logic       stop_watch;
    logic       set_alarm;
    logic       strtStp;
    logic [2:0] sw_lvl;

    int passCount;
    int totalChecks;
    int edgeIdx;
    int pulseCnt [4];
    int pulseFirst [4];
    int lvl1Cnt;

    input_cond #(.DB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SW         (SW),
        .KEY        (KEY),
        .set_time   (set_time),
        .stop_watch (stop_watch),
        .set_alarm  (set_alarm),
        .strtStp    (strtStp),
        .sw_lvl     (sw_lvl)
    );

    // 50 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        totalChecks++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Restarts the pulse bookkeeping and the edge index.
    task automatic clearCounts();
        edgeIdx = 0;
        lvl1Cnt = 0;
        for (int i = 0; i < 4; i++) begin
            pulseCnt[i]   = 0;
            pulseFirst[i] = 0;
        end
    endtask

    // Drives the raw inputs; optionally restarts the bookkeeping.
    task automatic applyStimulus(input logic [2:0] sw, input logic key, input bit clr);
        SW  = sw;
        KEY = key;
        if (clr) clearCounts();
    endtask

    // Runs n edges, counting high cycles of each pulse and where each first rose.
    task automatic runWindow(input int n);
        logic [3:0] p;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edgeIdx++;
            p = {strtStp, set_alarm, stop_watch, set_time};
            for (int k = 0; k < 4; k++) begin
                if (p[k]) begin
                    pulseCnt[k]++;
                    if (pulseFirst[k] == 0) pulseFirst[k] = edgeIdx;
                end
            end
            if (sw_lvl[1]) lvl1Cnt++;
        end
    endtask

    initial begin
        passCount   = 0;
        totalChecks = 0;
        rst_n       = 1'b0;

        // Reset held with SW[0] high and KEY pressed: nothing may leave the block.
        applyStimulus(3'b001, 1'b0, 1'b1);
        runWindow(4);
        checkOutput("reset_pulses", pulseCnt[0] + pulseCnt[1] + pulseCnt[2] + pulseCnt[3], 0);
        checkOutput("reset_sw_lvl", int'(sw_lvl), 0);

        // Release: both already-active inputs qualify as new activations.
        rst_n = 1'b1;
        clearCounts();
        runWindow(20);
        checkOutput("rel_set_time_cnt", pulseCnt[0], 1);
        checkOutput("rel_set_time_at", pulseFirst[0], FIRST);
        checkOutput("rel_strtStp_cnt", pulseCnt[3], 1);
        checkOutput("rel_strtStp_at", pulseFirst[3], FIRST);
        checkOutput("rel_other_cnt", pulseCnt[1] + pulseCnt[2], 0);
        checkOutput("rel_sw_lvl", int'(sw_lvl), 1);

        // Switch fall and key release produce no pulses.
        applyStimulus(3'b000, 1'b1, 1'b1);
        runWindow(20);
        checkOutput("fall_pulses", pulseCnt[0] + pulseCnt[1] + pulseCnt[2] + pulseCnt[3], 0);
        checkOutput("fall_sw_lvl", int'(sw_lvl), 0);

        // SW[0] rise held: one pulse at the qualified latency, level follows.
        applyStimulus(3'b001, 1'b1, 1'b1);
        runWindow(30);
        checkOutput("ts_cnt", pulseCnt[0], 1);
        checkOutput("ts_at", pulseFirst[0], FIRST);
        checkOutput("ts_other_cnt", pulseCnt[1] + pulseCnt[2] + pulseCnt[3], 0);
        checkOutput("ts_sw_lvl", int'(sw_lvl), 1);
        applyStimulus(3'b000, 1'b1, 1'b1);
        runWindow(20);
        checkOutput("ts_fall_cnt", pulseCnt[0], 0);

        // SW[1] high for 5 cycles: filtered when debouncing, passed otherwise.
        applyStimulus(3'b010, 1'b1, 1'b1);
        runWindow(5);
        applyStimulus(3'b000, 1'b1, 1'b0);
        runWindow(20);
        checkOutput("glitch_sw_cnt", pulseCnt[1], DEBOUNCE ? 0 : 1);
        checkOutput("glitch_lvl1_cycles", lvl1Cnt, DEBOUNCE ? 0 : 5);
        checkOutput("glitch_sw_lvl", int'(sw_lvl), 0);

        // KEY pressed 40 cycles then released: one pulse on press only.
        applyStimulus(3'b000, 1'b0, 1'b1);
        runWindow(40);
        applyStimulus(3'b000, 1'b1, 1'b0);
        runWindow(20);
        checkOutput("key_cnt", pulseCnt[3], 1);
        checkOutput("key_at", pulseFirst[3], FIRST);
        checkOutput("key_sw_pulses", pulseCnt[0] + pulseCnt[1] + pulseCnt[2], 0);

        // SW[0] and SW[2] together: both pulse in the same cycle.
        applyStimulus(3'b101, 1'b1, 1'b1);
        runWindow(20);
        checkOutput("sim_ts_cnt", pulseCnt[0], 1);
        checkOutput("sim_sa_cnt", pulseCnt[2], 1);
        checkOutput("sim_ts_at", pulseFirst[0], FIRST);
        checkOutput("sim_sa_at", pulseFirst[2], FIRST);
        checkOutput("sim_sw_lvl", int'(sw_lvl), 5);
        applyStimulus(3'b000, 1'b1, 1'b1);
        runWindow(20);
        checkOutput("sim_fall_sw_lvl", int'(sw_lvl), 0);

        // SW[2] rises, reset hits part-way through qualification.
        applyStimulus(3'b100, 1'b1, 1'b1);
        runWindow(7);
        checkOutput("rstmid_pre_cnt", pulseCnt[2], DEBOUNCE ? 0 : 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_async_sa", int'(set_alarm), 0);
        checkOutput("rstmid_async_lvl", int'(sw_lvl), 0);
        clearCounts();
        runWindow(3);
        checkOutput("rstmid_hold_cnt", pulseCnt[2], 0);
        rst_n = 1'b1;
        clearCounts();
        runWindow(20);
        checkOutput("rstmid_post_cnt", pulseCnt[2], 1);
        checkOutput("rstmid_post_at", pulseFirst[2], FIRST);
        checkOutput("rstmid_sw_lvl", int'(sw_lvl), 4);

        applyStimulus(3'b000, 1'b1, 1'b1);
        runWindow(20);

        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule

// File: doc/input_cond.md
INPUT_COND -- requirements
Module: input_cond

Interface
REQ-001 The module SHALL have parameter DB_CYCLES, default 500000, giving the debounce qualification time in clk cycles (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 The module SHALL have port clk, input, 1 bit: 50 MHz system clock; all state is on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The module SHALL have port SW, input, 3 bits: raw slide switches, asynchronous to clk; [0] set time, [1] stop watch, [2] set alarm.
REQ-005 The module SHALL have port KEY, input, 1 bit: raw start/stop pushbutton, active-low (0 = pressed), asynchronous.
REQ-006 The module SHALL have port set_time, output, 1 bit: one-cycle pulse on a qualified rise of SW[0].
REQ-007 The module SHALL have port stop_watch, output, 1 bit: one-cycle pulse on a qualified rise of SW[1].
REQ-008 The module SHALL have port set_alarm, output, 1 bit: one-cycle pulse on a qualified rise of SW[2].
REQ-009 The module SHALL have port strtStp, output, 1 bit: one-cycle pulse on a qualified press (1->0) of KEY.
REQ-010 The module SHALL have port sw_lvl, output, 3 bits: debounced stable level of SW.

Function
REQ-011 Each of the 4 inputs SHALL pass through its own 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-012 Each input SHALL have an independent debouncer: a stable register plus a counter of at least ceil(log2(DB_CYCLES)) bits.
REQ-013 On each edge where sync2 == stable, the counter SHALL load 0.
REQ-014 On each edge where sync2 != stable and counter < DB_CYCLES-1, the counter SHALL increment by 1.
REQ-015 On an edge where sync2 != stable and counter == DB_CYCLES-1, stable SHALL load sync2 and the counter SHALL load 0 (the update edge).
REQ-016 Latency: a raw change sampled at edge N SHALL produce a stable update at edge N+1+DB_CYCLES, provided the input holds steady throughout.
REQ-017 A raw excursion shorter than DB_CYCLES synchronized cycles SHALL clear the counter on its return and SHALL NOT change stable or pulse any output.
REQ-018 Pulse outputs SHALL be registered, go high in the cycle following the qualifying update edge, and stay high for exactly 1 cycle.
REQ-019 Switch pulses SHALL fire only on stable 0->1; a 1->0 stable update SHALL produce no pulse.
REQ-020 strtStp SHALL fire only on the KEY stable 1->0 update; release SHALL produce no pulse.
REQ-021 Simultaneous qualified events on several inputs SHALL each pulse in the same cycle; no arbitration (the downstream clock state machine prioritizes).
REQ-022 A held input SHALL produce only one pulse, regardless of hold duration.
REQ-023 sw_lvl SHALL equal the three switch stable registers directly.

Reset
REQ-024 rst_n low SHALL asynchronously clear all switch sync flops and stables to 0, set the KEY sync flops and stable to 1, clear all counters to 0, and drive every pulse output and sw_lvl to 0.
REQ-025 A switch already high when reset releases SHALL qualify as a rise, giving one pulse DB_CYCLES+2 cycles after release.
REQ-026 A reset asserted mid-qualification SHALL discard the partial count; no pulse SHALL result from the pre-reset activity.

Configuration
REQ-027 With macro DEBOUNCE_EN defined, the debouncers SHALL be built as specified in REQ-012 to REQ-017.
REQ-028 Without DEBOUNCE_EN, no counters SHALL exist, stable SHALL load sync2 every edge, latency SHALL be 2 edges, and DB_CYCLES SHALL be ignored; all pulse rules SHALL be unchanged.

Verification
REQ-029 The bench SHALL cover: DB_CYCLES=8, DEBOUNCE_EN defined, SW[0] 0->1 sampled at edge N and held -> set_time high for exactly the cycle following edge N+9, sw_lvl[0]=1.
REQ-030 The bench SHALL cover: SW[1] high for 5 cycles, then low -> stop_watch never pulses and sw_lvl[1] stays 0.
REQ-031 The bench SHALL cover: KEY pressed for 40 cycles, then released -> exactly one strtStp pulse, none on release.
REQ-032 The bench SHALL cover: SW[0] and SW[2] rise on the same edge -> set_time and set_alarm pulse in the same cycle.
REQ-033 The bench SHALL cover: rst_n pulsed low at count 5 while SW[2] rises -> no set_alarm pulse before reset release, then one pulse 10 cycles after release with SW[2] still high.
REQ-034 The bench SHALL cover: DEBOUNCE_EN undefined, SW[1] rise sampled at edge N -> stop_watch high for the cycle following edge N+2.
